// File: rtl/vga_scanout_if.sv
// Framebuffer read port and VGA video output of the scanout stage.
// The master side is the scanout block; the slave side is the RAM and display.
interface vga_scanout_if #(
  parameter int unsigned ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  re;
  logic [7:0]            rd_data;
  logic                  pattern_en;
  logic                  hsync;
  logic                  vsync;
  logic                  de;
  logic [7:0]            gray;
  logic                  frame_start;

  modport master (
    output read_addr, re, hsync, vsync, de, gray, frame_start,
    input  rd_data, pattern_en
  );

  modport slave (
    input  read_addr, re, hsync, vsync, de, gray, frame_start,
    output rd_data, pattern_en
  );
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout of a 160x120 Y framebuffer with 4x4 pixel replication.
// Three-stage pipeline: counters, address/control delay, registered outputs.
module vga_scanout #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned SRC_WIDTH  = 160
) (
  input  logic           pclk,
  input  logic           reset,
  vga_scanout_if.master  bus
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);

  logic [H_W-1:0]        h_cnt, h_nxt, h1;
  logic [V_W-1:0]        v_cnt, v_nxt;
  logic [ADDR_WIDTH-1:0] row_base, row_nxt, addr_q;
  logic                  h_wrap, active0, hs0, vs0, first0;
  logic                  re_q, active1, hs1, vs1, first1;
  logic                  de_q, hsync_q, vsync_q, fs_q;
  logic [7:0]            gray_q;

  // Stage 0 next-state: raster counters and the base address of the source row.
  always_comb begin
    h_wrap  = (h_cnt == H_W'(H_TOTAL - 1));
    h_nxt   = h_wrap ? '0 : h_cnt + H_W'(1);
    v_nxt   = v_cnt;
    row_nxt = row_base;
    if (h_wrap) begin
      if (v_cnt == V_W'(V_TOTAL - 1)) begin
        v_nxt   = '0;
        row_nxt = '0;
      end else begin
        v_nxt = v_cnt + V_W'(1);
        // Every fourth output line advances to the next source row.
        if (v_cnt[1:0] == 2'b11) begin
          row_nxt = row_base + ADDR_WIDTH'(SRC_WIDTH);
        end
      end
    end
  end

  // Stage 0 decode of the visible region and sync windows.
  always_comb begin
    active0 = (h_cnt < H_W'(H_ACTIVE)) && (v_cnt < V_W'(V_ACTIVE));
    hs0     = !((h_cnt >= H_W'(H_ACTIVE + H_FP)) &&
                (h_cnt <  H_W'(H_ACTIVE + H_FP + H_SYNC)));
    vs0     = !((v_cnt >= V_W'(V_ACTIVE + V_FP)) &&
                (v_cnt <  V_W'(V_ACTIVE + V_FP + V_SYNC)));
    first0  = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      row_base <= '0;
    end else begin
      h_cnt    <= h_nxt;
      v_cnt    <= v_nxt;
      row_base <= row_nxt;
    end
  end

  // Stage 1: read address (held through blanking) and control delayed to match RAM latency.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      re_q    <= 1'b0;
      active1 <= 1'b0;
      hs1     <= 1'b1;
      vs1     <= 1'b1;
      first1  <= 1'b0;
      h1      <= '0;
    end else begin
      if (active0) begin
        addr_q <= row_base + ADDR_WIDTH'(h_cnt >> 2);
      end
      re_q    <= active0;
      active1 <= active0;
      hs1     <= hs0;
      vs1     <= vs0;
      first1  <= first0;
      h1      <= h_cnt;
    end
  end

  // Stage 2: output registers; pixel forced to black outside the visible region.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      de_q    <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs_q    <= 1'b0;
      gray_q  <= '0;
    end else begin
      de_q    <= active1;
      hsync_q <= hs1;
      vsync_q <= vs1;
      fs_q    <= first1;
      if (!active1) begin
        gray_q <= '0;
      end else if (bus.pattern_en) begin
        gray_q <= {h1[5:0], 2'b00};
      end else begin
        gray_q <= bus.rd_data;
      end
    end
  end

  assign bus.read_addr   = addr_q;
  assign bus.re          = re_q;
  assign bus.de          = de_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.frame_start = fs_q;
  assign bus.gray        = gray_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: a full-timing instance for line-level checks and a
// short-frame instance (8 active lines) so whole frames and mid-frame reset fit the run.
module tb_vga_scanout;
  logic pclk = 1'b0;
  logic reset;
  logic pat;
  int   rd_mode;   // 0: RAM[a]=a[7:0], 1: constant FF, 2: constant AA
  int   tests = 0;
  int   fails = 0;

  always #20 pclk = ~pclk;

  vga_scanout_if #(.ADDR_WIDTH(15)) bf ();
  vga_scanout_if #(.ADDR_WIDTH(15)) bs ();

  assign bf.rd_data    = (rd_mode == 1) ? 8'hFF : (rd_mode == 2) ? 8'hAA : bf.read_addr[7:0];
  assign bs.rd_data    = (rd_mode == 1) ? 8'hFF : (rd_mode == 2) ? 8'hAA : bs.read_addr[7:0];
  assign bf.pattern_en = pat;
  assign bs.pattern_en = pat;

  vga_scanout u_full (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bf.master)
  );

  vga_scanout #(
    .V_ACTIVE (8),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (3)
  ) u_short (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bs.master)
  );

  typedef struct {
    int unsigned e;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [7:0]  gray;
  } vec_t;

  typedef struct {
    int unsigned e;
    logic        re;
    logic [14:0] addr;
  } avec_t;

  vec_t  vt[$];
  avec_t at[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt, per, low, de_cnt, vs_cnt, first_vs, next_fs;
    bit  found, prev, rose, done;

    // Expected outputs of the full-timing instance, edge count after reset release.
    vt.push_back('{1,    1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
    vt.push_back('{2,    1'b1, 1'b1, 1'b1, 1'b1, 8'h00});
    vt.push_back('{3,    1'b1, 1'b1, 1'b1, 1'b0, 8'h00});
    vt.push_back('{6,    1'b1, 1'b1, 1'b1, 1'b0, 8'h01});
    vt.push_back('{9,    1'b1, 1'b1, 1'b1, 1'b0, 8'h01});
    vt.push_back('{10,   1'b1, 1'b1, 1'b1, 1'b0, 8'h02});
    vt.push_back('{641,  1'b1, 1'b1, 1'b1, 1'b0, 8'h9F});
    vt.push_back('{642,  1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
    vt.push_back('{657,  1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
    vt.push_back('{658,  1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    vt.push_back('{753,  1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    vt.push_back('{754,  1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
    vt.push_back('{801,  1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
    vt.push_back('{802,  1'b1, 1'b1, 1'b1, 1'b0, 8'h00});
    vt.push_back('{3202, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA0});
    vt.push_back('{3206, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA1});
    at.push_back('{1,    1'b1, 15'd0});
    at.push_back('{2401, 1'b1, 15'd0});
    at.push_back('{3041, 1'b0, 15'd159});
    at.push_back('{3201, 1'b1, 15'd160});
    at.push_back('{3204, 1'b1, 15'd160});
    at.push_back('{3205, 1'b1, 15'd161});

    reset   = 1'b1;
    rd_mode = 1;
    pat     = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_hsync", 32'(bf.hsync), 32'(1));
    check("rst_vsync", 32'(bf.vsync), 32'(1));
    check("rst_de", 32'(bf.de), 32'(0));
    check("rst_gray", 32'(bf.gray), 32'(0));
    check("rst_frame_start", 32'(bf.frame_start), 32'(0));
    check("rst_re", 32'(bf.re), 32'(0));
    check("rst_read_addr", 32'(bf.read_addr), 32'(0));

    reset   = 1'b0;
    rd_mode = 0;
    for (int e = 1; e <= 3210; e++) begin
      tick();
      foreach (vt[i]) begin
        if (vt[i].e == e) begin
          check($sformatf("vec_de@%0d", e), 32'(bf.de), 32'(vt[i].de));
          check($sformatf("vec_hsync@%0d", e), 32'(bf.hsync), 32'(vt[i].hs));
          check($sformatf("vec_vsync@%0d", e), 32'(bf.vsync), 32'(vt[i].vs));
          check($sformatf("vec_fs@%0d", e), 32'(bf.frame_start), 32'(vt[i].fs));
          check($sformatf("vec_gray@%0d", e), 32'(bf.gray), 32'(vt[i].gray));
        end
      end
      foreach (at[i]) begin
        if (at[i].e == e) begin
          check($sformatf("addr_re@%0d", e), 32'(bf.re), 32'(at[i].re));
          check($sformatf("addr@%0d", e), 32'(bf.read_addr), 32'(at[i].addr));
        end
      end
    end

    // Blanking: with RAM data stuck at AA, gray is 0 exactly when de is low.
    rd_mode = 2;
    repeat (2) tick();
    cnt    = 0;
    de_cnt = 0;
    for (int n = 0; n < 800; n++) begin
      tick();
      if (!bf.de && bf.gray != 8'h00) cnt++;
      if (bf.de) begin
        de_cnt++;
        if (bf.gray != 8'hAA) cnt++;
      end
    end
    check("blank_gray_bad_cycles", 32'(cnt), 32'(0));
    check("de_cycles_per_line", 32'(de_cnt), 32'(640));
    rd_mode = 0;

    // Test pattern across one line.
    pat   = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      prev = bf.de;
      tick();
      if (!prev && bf.de) found = 1'b1;
    end
    check("pat_de_rise_seen", 32'(found), 32'(1));
    check("pat_px0", 32'(bf.gray), 32'(8'h00));
    repeat (5) tick();
    check("pat_px5", 32'(bf.gray), 32'(8'h14));
    repeat (634) tick();
    check("pat_px639", 32'(bf.gray), 32'(8'hFC));
    tick();
    check("pat_px640_de", 32'(bf.de), 32'(0));
    check("pat_px640_gray", 32'(bf.gray), 32'(0));
    pat = 1'b0;

    // Horizontal sync placement, width and period.
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      prev = bf.de;
      tick();
      if (prev && !bf.de) found = 1'b1;
    end
    check("hs_de_fall_seen", 32'(found), 32'(1));
    cnt   = 0;
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      tick();
      cnt++;
      if (!bf.hsync) found = 1'b1;
    end
    check("hs_start_after_de_fall", 32'(cnt), 32'(16));
    per  = 0;
    low  = 1;
    rose = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 2000 && !done; n++) begin
      tick();
      per++;
      if (!bf.hsync && !rose) low++;
      if (bf.hsync) rose = 1'b1;
      if (rose && !bf.hsync) done = 1'b1;
    end
    check("hs_low_width", 32'(low), 32'(96));
    check("hs_period", 32'(per), 32'(800));

    // Whole short frame: de count, vsync window, last-row address and wrap.
    found = 1'b0;
    for (int n = 0; n < 13000 && !found; n++) begin
      tick();
      if (bs.frame_start) found = 1'b1;
    end
    check("s_frame_start_seen", 32'(found), 32'(1));
    de_cnt   = 0;
    vs_cnt   = 0;
    first_vs = -1;
    next_fs  = -1;
    for (int k = 1; k <= 12000; k++) begin
      tick();
      if (bs.de) de_cnt++;
      if (!bs.vsync) begin
        vs_cnt++;
        if (first_vs < 0) first_vs = k;
      end
      if (bs.frame_start && next_fs < 0) next_fs = k;
      if (k == 6234) check("s_addr_h635_v7", 32'(bs.read_addr), 32'(318));
      if (k == 6235) begin
        check("s_addr_h636_v7", 32'(bs.read_addr), 32'(319));
        check("s_re_h636_v7", 32'(bs.re), 32'(1));
      end
      if (k == 6239) begin
        check("s_re_h640_v7", 32'(bs.re), 32'(0));
        check("s_addr_hold_h640", 32'(bs.read_addr), 32'(319));
      end
      if (k == 12000) check("s_wrap_de", 32'(bs.de), 32'(1));
    end
    check("s_de_cycles_frame", 32'(de_cnt), 32'(5120));
    check("s_vsync_low_cycles", 32'(vs_cnt), 32'(1600));
    check("s_vsync_start", 32'(first_vs), 32'(8000));
    check("s_frame_period", 32'(next_fs), 32'(12000));

    // Mid-frame reset at (h=300, v=5) of the short instance.
    repeat (4298) tick();
    check("mr_pre_de", 32'(bs.de), 32'(1));
    #5;
    reset = 1'b1;
    #1;
    check("mr_de", 32'(bs.de), 32'(0));
    check("mr_gray", 32'(bs.gray), 32'(0));
    check("mr_hsync", 32'(bs.hsync), 32'(1));
    check("mr_vsync", 32'(bs.vsync), 32'(1));
    check("mr_fs", 32'(bs.frame_start), 32'(0));
    check("mr_re", 32'(bs.re), 32'(0));
    check("mr_read_addr", 32'(bs.read_addr), 32'(0));
    check("mr_full_de", 32'(bf.de), 32'(0));
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("mr_e1_fs", 32'(bs.frame_start), 32'(0));
    check("mr_e1_de", 32'(bs.de), 32'(0));
    tick();
    check("mr_e2_fs", 32'(bs.frame_start), 32'(1));
    check("mr_e2_de", 32'(bs.de), 32'(1));
    check("mr_e2_gray", 32'(bs.gray), 32'(0));
    check("mr_e2_full_fs", 32'(bf.frame_start), 32'(1));
    first_vs = -1;
    next_fs  = -1;
    de_cnt   = 1;
    for (int k = 3; k <= 12002; k++) begin
      tick();
      if (bs.de && k < 12002) de_cnt++;
      if (!bs.vsync && first_vs < 0) first_vs = k;
      if (bs.frame_start && next_fs < 0) next_fs = k;
    end
    check("mr_de_cycles", 32'(de_cnt), 32'(5120));
    check("mr_vsync_start", 32'(first_vs), 32'(8002));
    check("mr_next_frame", 32'(next_fs), 32'(12002));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display-side stage of the camera path: reads the 160x120 8-bit Y framebuffer written by the capture stage and drives a 640x480@60 Hz VGA output. Each stored pixel is replicated 4x horizontally and 4x vertically. The block generates VGA timing and framebuffer read addresses, and aligns sync, blanking and pixel data across the synchronous-RAM read latency.

## Interface
- ADDR_WIDTH, 15, framebuffer address width (QQVGA, 19200 used words).
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pclk cycles (total 800).
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525).
- SRC_WIDTH, 160, framebuffer line length in pixels.
- pclk  in  1  VGA pixel clock, 25 MHz; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_data  in  8  framebuffer read data, valid one pclk after read_addr is presented.
- pattern_en  in  1  when high, output a test pattern instead of framebuffer data.
- read_addr  out  ADDR_WIDTH  framebuffer read address.
- re  out  1  read enable, high for active-region reads.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- de  out  1  display enable, high during visible pixels.
- gray  out  8  pixel intensity, driven to all colour channels by the top level.
- frame_start  out  1  one-cycle pulse aligned with the first visible output pixel of each frame.

## Operation
- Stage 0 counters:
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps and runs 0..524, wrapping to 0.
  - active0 = (h_cnt < 640) && (v_cnt < 480).
- Stage 0 sync:
  - hs0 is low when 656 <= h_cnt <= 751.
  - vs0 is low when 490 <= v_cnt <= 491.
- Stage 1 address:
  - read_addr <= (v_cnt>>2)*160 + (h_cnt>>2) when active0, otherwise it holds its value.
  - re <= active0.
  - The address may be computed incrementally, without a multiplier; the value must equal the formula.
  - Maximum address is 19199 and never exceeds 2^ADDR_WIDTH-1.
- Stage 1 control: hs0, vs0, active0 and the first-pixel flag (h_cnt==0 && v_cnt==0) are delayed one register.
- Stage 2 output registers:
  - de <= active1, hsync <= hs1, vsync <= vs1.
  - frame_start <= first1.
  - gray <= !active1 ? 0 : pattern_en ? {h1[5:0],2'b00} : rd_data, where h1 is h_cnt delayed one cycle.
- gray must be 0 whenever de is low, regardless of rd_data.
- Sync outputs are registered only and never driven combinationally from the counters.

## Timing
- Reset values:
  - h_cnt=0, v_cnt=0, read_addr=0, re=0.
  - hsync=1, vsync=1, de=0, gray=0, frame_start=0.
  - All pipeline registers are cleared to their inactive values.
- Latency: counter state at edge N appears on the outputs after edge N+2. All outputs share this latency, so the sync-to-pixel relationship matches standard 640x480 timing exactly.
- After reset release:
  - The first counter value (0,0) reaches the outputs on the 2nd rising edge.
  - de=1, frame_start=1 and gray=RAM[0] appear together on that edge.
- Line period is 800 cycles; hsync is low for 96 cycles, starting 16 cycles after de falls.
- Frame period is 420000 cycles; vsync is low for 1600 cycles, starting 10 lines after the last active line.
- Replication: read_addr is constant for 4 consecutive active cycles. A given 160-pixel source line is read on 4 consecutive output lines.
- Wrap: v_cnt 524→0 and h_cnt 799→0 occur on the same edge. The next frame starts with no gap cycle.
- pattern_en may toggle at any time and takes effect with the same 2-cycle latency. Timing is unaffected.
- Reset asserted mid-frame: outputs go to their reset values immediately (asynchronously). After release, timing restarts at (0,0) with no partial frame remnants.

## Test plan
- Reset check: hold reset, drive rd_data=8'hFF -> hsync=1, vsync=1, de=0, gray=0, frame_start=0, re=0.
- First pixel: release reset; model RAM[a]=a[7:0] -> 2nd edge gives de=1, frame_start=1, gray=0x00. Output pixels 4..7 give gray=0x01.
- Line addressing: observe read_addr at (h=0, v=3) = 0, (h=0, v=4) = 160, (h=636, v=479) = 19199. re is low for h>=640.
- Sync timing: measure hsync low width 96 and period 800; vsync low width 1600 and period 420000. de high for 640 cycles per line on 480 lines.
- Blanking and pattern: rd_data forced to 0xAA -> gray=0 whenever de=0. With pattern_en=1, output pixel 5 gives gray=0x14.
- Mid-frame reset: assert reset at v=200, h=300 -> outputs go to reset values immediately. After release, frame_start occurs 2 edges later and the full frame completes with correct timing.
